// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared types, defaults and helpers for the mem port|
// |               arbiter                                            |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int c_def_addr_w = 16;
    localparam int c_def_data_w = 129;

    // Bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_picker : combinational round-robin pick starting at ptr       |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    // Offset k from the pointer maps to position p, wrapping once past NUM_REQ.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int p = 0; p < NUM_REQ; p++) begin
                if (!any && req[p] &&
                    ((int'(ptr) + k == p) || (int'(ptr) + k == p + NUM_REQ))) begin
                    any      = 1'b1;
                    grant[p] = 1'b1;
                    idx      = PTR_W'(p);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_port_arbiter : round-robin sequencer sharing one memory port |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = c_def_addr_w,
    parameter int DATA_W  = c_def_data_w,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      err_spurious
);

    localparam int c_ptr_w = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int c_cnt_w = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_timeout  = c_cnt_w'(TIMEOUT);

    state_t               r_state;
    logic [c_ptr_w-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0]   r_owner_oh;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_mem_cmd_valid;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 r_err_spurious;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_ptr_w-1:0]   w_idx;
    logic                 w_any;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_picker (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // One-hot grant selects the winner's payload.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Gated by rst_n so nothing is accepted while reset is held.
    assign req_ready     = ((r_state == S_IDLE) && rst_n) ? w_grant : '0;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;
    assign mem_cmd_valid = r_mem_cmd_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign err_spurious  = r_err_spurious;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= '0;
            r_owner_oh      <= '0;
            r_cnt           <= '0;
            r_mem_cmd_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_rsp_valid     <= '0;
            r_rsp_rdata     <= '0;
            r_rsp_err       <= 1'b0;
            r_err_spurious  <= 1'b0;
        end else begin
            if (mem_rsp_valid && (r_state != S_WAIT)) begin
                r_err_spurious <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner_oh      <= w_grant;
                        r_mem_we        <= w_sel_we;
                        r_mem_addr      <= w_sel_addr;
                        r_mem_wdata     <= w_sel_wdata;
                        r_mem_cmd_valid <= 1'b1;
                        r_rr_ptr        <= (w_idx == c_last_idx) ? '0 : w_idx + 1'b1;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_cmd_ready) begin
                        r_mem_cmd_valid <= 1'b0;
                        r_cnt           <= '0;
                        if (r_mem_we) begin
                            r_rsp_valid <= r_owner_oh;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Returned data takes priority over a simultaneous expiry.
                    if (mem_rsp_valid) begin
                        r_rsp_rdata <= mem_rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= r_owner_oh;
                        r_state     <= S_RESP;
                    end else if (r_cnt == c_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_owner_oh;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench (TIMEOUT = 8) |
// | Revision            : 1.0                                        |
// +------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 129;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata, mem_wdata, mem_rdata;
    logic              rsp_err, mem_cmd_valid, mem_cmd_ready, mem_we;
    logic [AW-1:0]     mem_addr;
    logic              mem_rsp_valid, err_spurious;

    int errors = 0;
    int checks = 0;

    localparam logic [DW-1:0] c_wd_a = 129'h1_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [DW-1:0] c_rd_a = 129'h1_0000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [DW-1:0] c_wd_b = 129'h0_1234_5678_9ABC_DEF0_0F0F_F0F0_5555_AAAA;
    localparam logic [DW-1:0] c_rd_c = 129'h1_CAFE_0000_1111_2222_3333_4444_5555_6666;

    mem_port_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .err_spurious  (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        req_valid     = '0;
        req_we        = '0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if ({mem_cmd_valid, mem_we, rsp_err, err_spurious} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {mem_cmd_valid, mem_we, rsp_err, err_spurious}); end
        checks++; if (rsp_valid !== 4'b0000 || mem_addr !== 16'h0) begin errors++; $display("FAIL reset_rsp_addr got rsp_valid=%b mem_addr=%h exp 0/0", rsp_valid, mem_addr); end
        checks++; if (rsp_rdata !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_data got rdata=%h wdata=%h exp 0", rsp_rdata, mem_wdata); end
        req_valid = '0;
        rst_n     = 1'b1;
        @(negedge clk);
        checks++; if (mem_cmd_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL idle_quiet got cmd_valid=%b req_ready=%b exp 0", mem_cmd_valid, req_ready); end
    endtask

    task automatic test_write();
        do_reset();
        set_req(2, 1'b1, 16'h0040, c_wd_a);
        req_valid     = 4'b0100;
        mem_cmd_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wr_accept got=%b exp=0100", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wr_no_ready_in_issue got=%b exp=0000", req_ready); end
        checks++; if (mem_cmd_valid !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_cmd got valid=%b we=%b exp 1/1", mem_cmd_valid, mem_we); end
        checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL wr_addr got=%h exp=0040", mem_addr); end
        checks++; if (mem_wdata !== c_wd_a) begin errors++; $display("FAIL wr_wdata got=%h exp=%h", mem_wdata, c_wd_a); end
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp got valid=%b err=%b exp 0100/0", rsp_valid, rsp_err); end
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_rsp_one_cycle got=%b exp=0000", rsp_valid); end
    endtask

    task automatic test_read();
        logic early;
        early = 1'b0;
        set_req(0, 1'b0, 16'h0100, '0);
        req_valid     = 4'b0001;
        mem_cmd_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rd_accept got=%b exp=0001", req_ready); end
        @(negedge clk);
        checks++; if (mem_cmd_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0100) begin errors++; $display("FAIL rd_cmd got valid=%b we=%b addr=%h exp 1/0/0100", mem_cmd_valid, mem_we, mem_addr); end
        req_valid = '0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL rd_early_rsp got=1 exp=0"); end
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata     = c_rd_a;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp got valid=%b err=%b exp 0001/0", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== c_rd_a) begin errors++; $display("FAIL rd_data got=%h exp=%h", rsp_rdata, c_rd_a); end
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0000 || err_spurious !== 1'b0) begin errors++; $display("FAIL rd_after got valid=%b spurious=%b exp 0000/0", rsp_valid, err_spurious); end
    endtask

    task automatic test_grant_order(input logic [N-1:0] valid_mask, input int num, input int single);
        int n;
        int last;
        logic [N-1:0] exp;
        n    = 0;
        last = 0;
        req_we        = 4'b1111;
        req_valid     = valid_mask;
        mem_cmd_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n < num; cyc++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                exp = (single >= 0) ? N'(1 << single) : N'(1 << (n % N));
                checks++; if (req_ready !== exp) begin errors++; $display("FAIL grant_%0d got=%b exp=%b", n, req_ready, exp); end
                if (n > 0) begin
                    checks++; if (cyc - last != 3) begin errors++; $display("FAIL grant_gap_%0d got=%0d exp=3", n, cyc - last); end
                end
                last = cyc;
                n++;
            end
            @(negedge clk);
        end
        checks++; if (n != num) begin errors++; $display("FAIL grant_count got=%0d exp=%0d", n, num); end
        req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] wrong;
        mem_cmd_ready = 1'b0;
        set_req(3, 1'b1, 16'h1234, c_wd_b);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_accept got=%b exp=1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        set_req(3, 1'b0, 16'hFFFF, '0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (mem_cmd_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h1234 ||
                mem_wdata !== c_wd_b || rsp_valid !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold_%0d got valid=%b we=%b addr=%h rsp=%b exp 1/1/1234/0000", i, mem_cmd_valid, mem_we, mem_addr, rsp_valid);
            end
            if (i < 9) @(negedge clk);
        end
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        wrong = rsp_valid;
        checks++; if (wrong !== 4'b1000 || mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_done got rsp=%b cmd_valid=%b exp 1000/0", wrong, mem_cmd_valid); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cnt;
        set_req(1, 1'b0, 16'h0200, '0);
        mem_rdata     = c_rd_c;
        mem_cmd_ready = 1'b1;
        req_valid     = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_accept got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        cnt = 0;
        while (rsp_valid === 4'b0000 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (cnt != 9) begin errors++; $display("FAIL to_latency got=%0d exp=9", cnt); end
        checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp got valid=%b err=%b exp 0010/1", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL to_rdata got=%h exp=0", rsp_rdata); end
        @(negedge clk);
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL spur_before got=%b exp=0", err_spurious); end
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_set got=%b exp=1", err_spurious); end
        @(negedge clk);
        checks++; if (err_spurious !== 1'b1 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL spur_sticky got=%b rsp=%b exp 1/0000", err_spurious, rsp_valid); end
    endtask

    task automatic test_data_at_expiry();
        set_req(0, 1'b0, 16'h0300, '0);
        mem_cmd_ready = 1'b1;
        req_valid     = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL exp_accept got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        repeat (8) @(negedge clk);
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL exp_early got=%b exp=0000", rsp_valid); end
        mem_rsp_valid = 1'b1;
        mem_rdata     = c_rd_c;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin errors++; $display("FAIL exp_rsp got valid=%b err=%b exp 0001/0", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== c_rd_c) begin errors++; $display("FAIL exp_data got=%h exp=%h", rsp_rdata, c_rd_c); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_req(2, 1'b0, 16'h0ABC, '0);
        mem_cmd_ready = 1'b1;
        req_valid     = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_accept got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        set_req(0, 1'b1, 16'h0011, c_wd_a);
        set_req(1, 1'b1, 16'h0022, c_wd_a);
        set_req(2, 1'b1, 16'h0033, c_wd_a);
        set_req(3, 1'b1, 16'h0044, c_wd_a);
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_ports got ready=%b rsp=%b exp 0000/0000", req_ready, rsp_valid); end
        checks++; if (mem_addr !== 16'h0 || rsp_rdata !== '0 || err_spurious !== 1'b0) begin errors++; $display("FAIL rm_regs got addr=%h rdata=%h spur=%b exp 0", mem_addr, rsp_rdata, err_spurious); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (mem_cmd_valid !== 1'b1 || mem_addr !== 16'h0011) begin errors++; $display("FAIL rm_cmd got valid=%b addr=%h exp 1/0011", mem_cmd_valid, mem_addr); end
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rm_rsp got=%b exp=0001", rsp_valid); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        do_reset();
        test_grant_order(4'b1111, 8, -1);
        test_grant_order(4'b0010, 3, 1);
        test_backpressure();
        test_timeout();
        test_data_at_expiry();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
